// File: rtl/oddr2_feeder_pkg.sv
// Shared types and limits for the ODDR2 feeder: FSM state encoding and underrun saturation.
package oddr2_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == UNDERRUN_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/oddr2_feeder_sync_fifo.sv
// Synchronous FIFO, no bypass: a push is poppable the following cycle, read data is the head entry.
// Pushes while full and pops while empty are ignored; count/full/empty are from registered pointers.
module sync_fifo #(
    parameter int DW2   = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW2-1:0]           i_dat,
    output logic [DW2-1:0]           o_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW2-1:0] r_mem [DEPTH];
    logic [AW:0]    r_wr;
    logic [AW:0]    r_rd;
    logic           w_wr_en;
    logic           w_rd_en;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign o_empty = (r_wr == r_rd);
    assign o_full  = ((r_wr ^ r_rd) == {1'b1, {AW{1'b0}}});
    assign o_count = r_wr - r_rd;
    assign o_dat   = r_mem[r_rd[AW-1:0]];
    assign w_wr_en = i_push & ~o_full;
    assign w_rd_en = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/oddr2_feeder.sv
// Feeds ODDR2 D0/D1/CE from a FIFO of 2*DW words; first data on d0/d1 two cycles after its push.
// din_ready drops when full, disabled or draining; RUN-state empty cycles emit IDLE_PAT and count.
module oddr2_feeder
    import oddr2_feeder_pkg::*;
#(
    parameter int             DW        = 8,
    parameter int             DEPTH     = 4,
    parameter int             PRIME_LVL = 2,
    parameter logic [DW-1:0]  IDLE_PAT  = '0
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              enable,
    input  logic [2*DW-1:0]   din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DW-1:0]     d0,
    output logic [DW-1:0]     d1,
    output logic              oddr_ce,
    output logic              data_valid,
    output logic              busy,
    output logic [15:0]       underrun_cnt
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] PRIME_CNT = (AW+1)'(PRIME_LVL);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DW-1:0]      r_d0;
    logic [DW-1:0]      r_d1;
    logic               r_ce;
    logic               r_dv;
    logic [15:0]        r_ur_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [AW:0]        w_count;
    logic [2*DW-1:0]    w_fifo_dat;

    assign din_ready    = enable & ~w_full & (r_state != ST_DRAIN);
    assign w_push       = din_valid & din_ready;
    assign w_pop        = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) & ~w_empty;
    assign busy         = (r_state != ST_IDLE);
    assign d0           = r_d0;
    assign d1           = r_d1;
    assign oddr_ce      = r_ce;
    assign data_valid   = r_dv;
    assign underrun_cnt = r_ur_cnt;

    sync_fifo #(
        .DW2   (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (din),
        .o_dat   (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable takes priority over priming so a stalled stream never enters RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable)                   w_state_nxt = w_empty ? ST_IDLE : ST_DRAIN;
                else if (w_count >= PRIME_CNT) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_count <= ONE_CNT) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_d0     <= IDLE_PAT;
            r_d1     <= IDLE_PAT;
            r_ce     <= 1'b0;
            r_dv     <= 1'b0;
            r_ur_cnt <= '0;
        end else begin
            r_ce <= (r_state != ST_IDLE);
            if (w_pop) begin
                r_d0 <= w_fifo_dat[DW-1:0];
                r_d1 <= w_fifo_dat[2*DW-1:DW];
                r_dv <= 1'b1;
            end else begin
                r_d0 <= IDLE_PAT;
                r_d1 <= IDLE_PAT;
                r_dv <= 1'b0;
            end
            if ((r_state == ST_RUN) && w_empty) begin
                r_ur_cnt <= sat_inc(r_ur_cnt);
            end
        end
    end

endmodule

// File: tb/tb_oddr2_feeder.sv
// Bench for oddr2_feeder: two instances (PRIME_LVL 2 and 4) share stimulus, each tracked by a queue model.
module tb_oddr2_feeder;
    localparam int         DW       = 8;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] IDLE_PAT = 8'h3C;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din = '0;

    logic [1:0]        o_rdy, o_ce, o_dv, o_busy;
    logic [1:0][7:0]   o_d0, o_d1;
    logic [1:0][15:0]  o_ur;

    always #5 clk = ~clk;

    oddr2_feeder #(.DW(DW), .DEPTH(DEPTH), .PRIME_LVL(2), .IDLE_PAT(IDLE_PAT)) u_a (
        .clk(clk), .resetb(resetb), .enable(enable), .din(din), .din_valid(din_valid),
        .din_ready(o_rdy[0]), .d0(o_d0[0]), .d1(o_d1[0]), .oddr_ce(o_ce[0]),
        .data_valid(o_dv[0]), .busy(o_busy[0]), .underrun_cnt(o_ur[0]));

    oddr2_feeder #(.DW(DW), .DEPTH(DEPTH), .PRIME_LVL(4), .IDLE_PAT(IDLE_PAT)) u_b (
        .clk(clk), .resetb(resetb), .enable(enable), .din(din), .din_valid(din_valid),
        .din_ready(o_rdy[1]), .d0(o_d0[1]), .d1(o_d1[1]), .oddr_ce(o_ce[1]),
        .data_valid(o_dv[1]), .busy(o_busy[1]), .underrun_cnt(o_ur[1]));

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b1;
    bit  b_acc  = 1'b0;

    // Reference model: per instance a word queue, a mode and the expected registered outputs.
    int          ms [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [7:0]  e_d0 [2];
    logic [7:0]  e_d1 [2];
    logic        e_ce [2];
    logic        e_dv [2];
    logic [15:0] e_ur [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k != 0) ? q1.size() : q0.size();
    endfunction

    function automatic int plvl(input int k);
        return (k != 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = M_IDLE; e_d0[k] = IDLE_PAT; e_d1[k] = IDLE_PAT;
            e_ce[k] = 1'b0; e_dv[k] = 1'b0; e_ur[k] = 16'd0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge(input int k);
        int          n;
        int          nx;
        bit          rdy;
        bit          pop;
        logic [15:0] w;
        n   = qsize(k);
        nx  = ms[k];
        rdy = enable && (n < DEPTH) && (ms[k] != M_DRAIN);
        pop = ((ms[k] == M_RUN) || (ms[k] == M_DRAIN)) && (n > 0);
        e_ce[k] = (ms[k] != M_IDLE);
        if (pop) begin
            if (k != 0) w = q1.pop_front(); else w = q0.pop_front();
            e_d0[k] = w[7:0]; e_d1[k] = w[15:8]; e_dv[k] = 1'b1;
        end else begin
            e_d0[k] = IDLE_PAT; e_d1[k] = IDLE_PAT; e_dv[k] = 1'b0;
        end
        if ((ms[k] == M_RUN) && (n == 0) && (e_ur[k] != 16'hFFFF)) e_ur[k] = e_ur[k] + 16'd1;
        case (ms[k])
            M_IDLE:  if (enable) nx = M_PRIME;
            M_PRIME: if (!enable) nx = (n > 0) ? M_DRAIN : M_IDLE;
                     else if (n >= plvl(k)) nx = M_RUN;
            M_RUN:   if (!enable) nx = M_DRAIN;
            default: if (n <= 1) nx = M_IDLE;
        endcase
        ms[k] = nx;
        if (rdy && din_valid) begin
            if (k != 0) q1.push_back(din); else q0.push_back(din);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        b_acc = o_rdy[1] & din_valid;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rdy%0d", k), 32'(o_rdy[k]),
                    32'(enable && (qsize(k) < DEPTH) && (ms[k] != M_DRAIN)));
                chk($sformatf("busy_pre%0d", k), 32'(o_busy[k]), 32'(ms[k] != M_IDLE));
            end
        end
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d0_%0d", k), 32'(o_d0[k]), 32'(e_d0[k]));
                chk($sformatf("d1_%0d", k), 32'(o_d1[k]), 32'(e_d1[k]));
                chk($sformatf("ce%0d", k), 32'(o_ce[k]), 32'(e_ce[k]));
                chk($sformatf("dv%0d", k), 32'(o_dv[k]), 32'(e_dv[k]));
                chk($sformatf("ur%0d", k), 32'(o_ur[k]), 32'(e_ur[k]));
                chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(ms[k] != M_IDLE));
            end
        end
    endtask

    task automatic do_reset(input bit check);
        resetb = 1'b0; enable = 1'b0; din_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        if (check) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_d0_%0d", k), 32'(o_d0[k]), 32'(IDLE_PAT));
                chk($sformatf("rst_d1_%0d", k), 32'(o_d1[k]), 32'(IDLE_PAT));
                chk($sformatf("rst_ce%0d", k), 32'(o_ce[k]), 32'd0);
                chk($sformatf("rst_dv%0d", k), 32'(o_dv[k]), 32'd0);
                chk($sformatf("rst_busy%0d", k), 32'(o_busy[k]), 32'd0);
                chk($sformatf("rst_ur%0d", k), 32'(o_ur[k]), 32'd0);
                chk($sformatf("rst_rdy%0d", k), 32'(o_rdy[k]), 32'd0);
            end
        end
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nvalid;
        int          stall;
        int          stall_first4;
        bit          found;
        bit          ce_dropped;
        logic [7:0]  got_d0 [8];
        logic [7:0]  got_d1 [8];
        logic        seq_dv [6];
        logic        seq_ce [6];
        logic        seq_busy [6];
        logic [15:0] words [5];

        do_reset(1'b1);

        // Reset mid-RUN with three words still queued in the PRIME_LVL=4 instance.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 16'hA001 + 16'(i); din_valid = 1'b1; cyc();
        end
        din_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if ((ms[1] == M_RUN) && (qsize(1) == 3)) found = 1'b1;
        end
        chk("t1_run_reached", 32'(found), 32'd1);
        chk("t1_busy_before_rst", 32'(o_busy[1]), 32'd1);
        do_reset(1'b1);

        // Prime and first-data latency.
        enable = 1'b1; din_valid = 1'b1; din = 16'hB2A1; cyc();
        din = 16'hD4C3; cyc();
        din_valid = 1'b0;
        nvalid = 0; ce_dropped = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (o_dv[0]) begin
                got_d0[nvalid] = o_d0[0]; got_d1[nvalid] = o_d1[0]; nvalid++;
            end
            if (i > 0 && !o_ce[0]) ce_dropped = 1'b1;
        end
        chk("t2_nvalid", 32'(nvalid), 32'd2);
        chk("t2_w0_d0", 32'(got_d0[0]), 32'h A1);
        chk("t2_w0_d1", 32'(got_d1[0]), 32'h B2);
        chk("t2_w1_d0", 32'(got_d0[1]), 32'h C3);
        chk("t2_w1_d1", 32'(got_d1[1]), 32'h D4);
        chk("t3_underrun5", 32'(o_ur[0]), 32'd5);
        chk("t3_d0_idle", 32'(o_d0[0]), 32'(IDLE_PAT));
        chk("t3_d1_idle", 32'(o_d1[0]), 32'(IDLE_PAT));
        chk("t3_dv_low", 32'(o_dv[0]), 32'd0);
        chk("t3_ce_held", 32'(ce_dropped), 32'd0);
        chk("t3_b_no_underrun", 32'(o_ur[1]), 32'd0);

        // Fill the PRIME_LVL=4 instance; the 5th word waits for RUN to pop.
        do_reset(1'b0);
        words = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505};
        enable = 1'b1;
        stall_first4 = 0; stall = 0;
        for (int w = 0; w < 5; w++) begin
            din = words[w]; din_valid = 1'b1;
            b_acc = 1'b0;
            for (int t = 0; t < 10 && !b_acc; t++) begin
                cyc();
                if (!b_acc) begin
                    if (w < 4) stall_first4++; else stall++;
                end
            end
            if (w == 3) chk("t4_rdy_after_4th", 32'(o_rdy[1]), 32'd0);
        end
        chk("t4_first4_no_stall", 32'(stall_first4), 32'd0);
        chk("t4_5th_held", 32'(stall), 32'd2);

        // Drain: three queued words leave, then IDLE.
        din_valid = 1'b0; enable = 1'b0;
        #1;
        chk("t5_rdy_drop", 32'(o_rdy[1]), 32'd0);
        nvalid = 0;
        for (int j = 0; j < 6; j++) begin
            cyc();
            seq_dv[j] = o_dv[1]; seq_ce[j] = o_ce[1]; seq_busy[j] = o_busy[1];
            if (j < 3) got_d0[j] = o_d0[1];
            if (o_dv[1]) nvalid++;
        end
        chk("t5_nvalid", 32'(nvalid), 32'd3);
        chk("t5_p0", 32'(got_d0[0]), 32'h03);
        chk("t5_p1", 32'(got_d0[1]), 32'h04);
        chk("t5_p2", 32'(got_d0[2]), 32'h05);
        chk("t5_dv_last", 32'(seq_dv[2]), 32'd1);
        chk("t5_ce_last_pair", 32'(seq_ce[2]), 32'd1);
        chk("t5_idle_busy", 32'(seq_busy[2]), 32'd0);
        chk("t5_ce_off", 32'(seq_ce[3]), 32'd0);

        // Randomized traffic with enable toggling.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) enable = ($urandom_range(0, 19) != 0);
            else          enable = ($urandom_range(0, 3) != 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din = 16'($urandom);
            cyc();
        end

        // Underrun saturation.
        do_reset(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 16'h7000 + 16'(i); din_valid = 1'b1; cyc();
        end
        din_valid = 1'b0;
        for (int i = 0; i < 65600; i++) begin
            chk_en = (i % 8192 == 0);
            cyc();
        end
        chk_en = 1'b1;
        cyc();
        chk("t6_sat_a", 32'(o_ur[0]), 32'hFFFF);
        chk("t6_sat_b", 32'(o_ur[1]), 32'hFFFF);
        chk("t6_ce", 32'(o_ce[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
